// File: rtl/byte_pack16.sv
// byte_pack16: pairs consecutive DATA_W-bit bytes into registered 2*DATA_W-bit words over valid/ready.
// Ports: clk/rst (sync, active-high); in_data/in_valid/in_ready byte input;
// out_data/out_valid/out_ready word output; flush completes a held half word with zero
// only when PACK_FLUSH_EN is defined (port is present but ignored otherwise).
module byte_pack16 #(
  parameter int DATA_W   = 8,
  parameter int LO_FIRST = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [2*DATA_W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                flush
);
  typedef enum logic {S_LO, S_HI} state_t;
  state_t              r_state;
  logic [DATA_W-1:0]   r_hold;
  logic [2*DATA_W-1:0] r_data;
  logic                r_valid;
  logic                w_in_acc;
  logic                w_flush;
  logic                w_pair;
  logic [DATA_W-1:0]   w_byte;
  logic [2*DATA_W-1:0] w_word;
  assign in_ready = (r_state == S_LO) || !r_valid || out_ready;
  assign w_in_acc = in_valid && in_ready;
`ifdef PACK_FLUSH_EN
  // an input byte in the same cycle takes priority over flush
  assign w_flush = flush && !in_valid && in_ready && (r_state == S_HI);
`else
  logic w_unused_flush;
  assign w_unused_flush = flush;
  assign w_flush = 1'b0;
`endif
  assign w_pair = (r_state == S_HI) && (w_in_acc || w_flush);
  assign w_byte = w_in_acc ? in_data : '0;
  assign w_word = (LO_FIRST != 0) ? {w_byte, r_hold} : {r_hold, w_byte};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LO;
      r_hold  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_pair) begin
      r_data  <= w_word;
      r_valid <= 1'b1;
      r_state <= S_LO;
    end else begin
      if (out_ready) r_valid <= 1'b0;
      if (r_state == S_LO && in_valid) begin
        r_hold  <= in_data;
        r_state <= S_HI;
      end
    end
  end
  assign out_data  = r_data;
  assign out_valid = r_valid;
endmodule
